apb_decode_node: RTL and testbench

APB decode and protocol-conversion stage that sits directly downstream of the AXI-to-APB bridge. It takes the bridge's single-phase request (PSEL tied high, PENABLE = request, held until PREADY) and issues standard two-phase SETUP/ACCESS APB transfers to one of NB_SLAVES peripherals, selected by inclusive address ranges. It returns a registered one-cycle PREADY pulse with read data and error upstream. Unmapped addresses and, optionally, hung peripherals are answered with PSLVERR.

---
 rtl/apb_decode_node_if.sv | 41 ++++
 rtl/apb_decode_node.sv | 177 +++++++++++++++++
 tb/tb_apb_decode_node.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_decode_node_if.sv
// Bus bundle around apb_decode_node: upstream single-phase request side (s_*)
// and downstream two-phase APB peripheral side (m_*).
interface apb_decode_node_if #(
   parameter int NB_SLAVES      = 4,
   parameter int APB_ADDR_WIDTH = 32,
   parameter int APB_DATA_WIDTH = 32
) ();
   logic                                s_psel_i;
   logic                                s_penable_i;
   logic                                s_pwrite_i;
   logic [APB_ADDR_WIDTH-1:0]           s_paddr_i;
   logic [APB_DATA_WIDTH-1:0]           s_pwdata_i;
   logic [APB_DATA_WIDTH-1:0]           s_prdata_o;
   logic                                s_pready_o;
   logic                                s_pslverr_o;

   logic [NB_SLAVES-1:0]                m_psel_o;
   logic                                m_penable_o;
   logic                                m_pwrite_o;
   logic [APB_ADDR_WIDTH-1:0]           m_paddr_o;
   logic [APB_DATA_WIDTH-1:0]           m_pwdata_o;
   logic [NB_SLAVES*APB_DATA_WIDTH-1:0] m_prdata_i;
   logic [NB_SLAVES-1:0]                m_pready_i;
   logic [NB_SLAVES-1:0]                m_pslverr_i;

   // The decode node itself.
   modport slave (
      input  s_psel_i, s_penable_i, s_pwrite_i, s_paddr_i, s_pwdata_i,
      output s_prdata_o, s_pready_o, s_pslverr_o,
      output m_psel_o, m_penable_o, m_pwrite_o, m_paddr_o, m_pwdata_o,
      input  m_prdata_i, m_pready_i, m_pslverr_i
   );

   // The surroundings: upstream bridge plus downstream peripherals.
   modport master (
      output s_psel_i, s_penable_i, s_pwrite_i, s_paddr_i, s_pwdata_i,
      input  s_prdata_o, s_pready_o, s_pslverr_o,
      input  m_psel_o, m_penable_o, m_pwrite_o, m_paddr_o, m_pwdata_o,
      output m_prdata_i, m_pready_i, m_pslverr_i
   );
endinterface

// File: rtl/apb_decode_node.sv
// Address-range decoder converting the bridge's single-phase request into SETUP/ACCESS APB
// transfers. Optional ACCESS timeout is enabled by defining APB_NODE_TIMEOUT_EN.
module apb_decode_node #(
   parameter int NB_SLAVES      = 4,
   parameter int APB_ADDR_WIDTH = 32,
   parameter int APB_DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                                ACLK,
   input  logic                                ARESETn,
   input  logic [NB_SLAVES*APB_ADDR_WIDTH-1:0] start_addr_i,
   input  logic [NB_SLAVES*APB_ADDR_WIDTH-1:0] end_addr_i,
   apb_decode_node_if.slave                    bus
);
   localparam int IDX_W = (NB_SLAVES > 1) ? $clog2(NB_SLAVES) : 1;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

   state_e                    state_q, state_d;
   logic                      pwrite_q, pwrite_d;
   logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic [NB_SLAVES-1:0]      psel_q, psel_d;
   logic                      penable_q, penable_d;
   logic                      pready_q, pready_d;
   logic                      pslverr_q, pslverr_d;
   logic [APB_DATA_WIDTH-1:0] prdata_q, prdata_d;

   logic                      req;
   logic                      hit;
   logic [IDX_W-1:0]          hit_idx;
   logic                      sel_pready;
   logic                      sel_pslverr;
   logic [APB_DATA_WIDTH-1:0] sel_prdata;

`ifdef APB_NODE_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout;
   // cnt_q counts ACCESS cycles already spent; this is the last allowed one.
   assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

   assign req = bus.s_psel_i & bus.s_penable_i;

   // Descending scan so the lowest matching index is the one left standing.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = NB_SLAVES - 1; i >= 0; i--) begin
         if ((bus.s_paddr_i >= start_addr_i[i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH]) &&
             (bus.s_paddr_i <= end_addr_i[i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH])) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(i);
         end
      end
   end

   assign sel_pready  = bus.m_pready_i[idx_q];
   assign sel_pslverr = bus.m_pslverr_i[idx_q];
   assign sel_prdata  = bus.m_prdata_i[int'(idx_q)*APB_DATA_WIDTH +: APB_DATA_WIDTH];

   always_comb begin
      state_d   = state_q;
      pwrite_d  = pwrite_q;
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
      idx_d     = idx_q;
      psel_d    = psel_q;
      penable_d = penable_q;
      pready_d  = 1'b0;
      pslverr_d = pslverr_q;
      prdata_d  = prdata_q;
`ifdef APB_NODE_TIMEOUT_EN
      cnt_d     = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (req) begin
               pwrite_d = bus.s_pwrite_i;
               paddr_d  = bus.s_paddr_i;
               pwdata_d = bus.s_pwdata_i;
               idx_d    = hit_idx;
               if (hit) begin
                  psel_d  = NB_SLAVES'(1) << hit_idx;
                  state_d = SETUP;
               end else begin
                  pready_d  = 1'b1;
                  pslverr_d = 1'b1;
                  prdata_d  = '0;
                  state_d   = RESP;
               end
            end
         end
         SETUP: begin
            penable_d = 1'b1;
            state_d   = ACCESS;
`ifdef APB_NODE_TIMEOUT_EN
            cnt_d     = '0;
`endif
         end
         ACCESS: begin
            if (sel_pready) begin
               prdata_d  = pwrite_q ? '0 : sel_prdata;
               pslverr_d = sel_pslverr;
               psel_d    = '0;
               penable_d = 1'b0;
               pready_d  = 1'b1;
               state_d   = RESP;
            end
`ifdef APB_NODE_TIMEOUT_EN
            else if (timeout) begin
               prdata_d  = '0;
               pslverr_d = 1'b1;
               psel_d    = '0;
               penable_d = 1'b0;
               pready_d  = 1'b1;
               state_d   = RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            psel_d    = '0;
            penable_d = 1'b0;
            state_d   = IDLE;
         end
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q   <= IDLE;
         pwrite_q  <= 1'b0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         idx_q     <= '0;
         psel_q    <= '0;
         penable_q <= 1'b0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
      end else begin
         state_q   <= state_d;
         pwrite_q  <= pwrite_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
         idx_q     <= idx_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
         prdata_q  <= prdata_d;
      end
   end

`ifdef APB_NODE_TIMEOUT_EN
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end
`endif

   assign bus.s_prdata_o  = prdata_q;
   assign bus.s_pready_o  = pready_q;
   assign bus.s_pslverr_o = pslverr_q;
   assign bus.m_psel_o    = psel_q;
   assign bus.m_penable_o = penable_q;
   assign bus.m_pwrite_o  = pwrite_q;
   assign bus.m_paddr_o   = paddr_q;
   assign bus.m_pwdata_o  = pwdata_q;
endmodule

// File: tb/tb_apb_decode_node.sv
// Bench for apb_decode_node: directed vector table, reset/timeout sequences and
// randomized transfers checked against an address-map reference model.
module tb_apb_decode_node;
   localparam int NS = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 8;

   logic ACLK;
   logic ARESETn;
   logic [NS*AW-1:0] start_flat;
   logic [NS*AW-1:0] end_flat;

   int n_vec = 0;
   int n_bad = 0;

   logic [31:0] start_a [NS];
   logic [31:0] end_a   [NS];

   apb_decode_node_if #(.NB_SLAVES(NS), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW)) bus ();

   apb_decode_node #(
      .NB_SLAVES(NS), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .start_addr_i(start_flat), .end_addr_i(end_flat),
      .bus(bus)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [31:0] wdata;
      int          waits;
      logic        serr;
      int          exp_lat;
      logic        exp_err;
      logic [31:0] exp_rdata;
      logic [3:0]  exp_sel;
   } vec_t;

   vec_t tbl [11];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: first range (lowest index) containing the address, else -1.
   function automatic int ref_idx(input logic [31:0] addr);
      for (int k = 0; k < NS; k++)
         if (addr >= start_a[k] && addr <= end_a[k]) return k;
      return -1;
   endfunction

   function automatic bit ref_timed_out(input int tgt, input int waits);
`ifdef APB_NODE_TIMEOUT_EN
      return (tgt >= 0) && (waits >= TO);
`else
      return 1'b0;
`endif
   endfunction

   function automatic int ref_lat(input int tgt, input int waits);
      if (tgt < 0) return 1;
      if (ref_timed_out(tgt, waits)) return 2 + TO;
      return 3 + waits;
   endfunction

   // Drives one upstream request and plays the peripherals; starts and ends #1 after a posedge.
   task automatic run_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                           input int waits, input logic serr, input logic [31:0] base,
                           output int lat, output logic err, output logic [31:0] rdata,
                           output logic [3:0] sel_seen, output logic proto_ok);
      int         tgt;
      int         w;
      bit         done;
      logic [3:0] onehot;
      tgt      = ref_idx(addr);
      onehot   = (tgt < 0) ? 4'b0000 : 4'(1 << tgt);
      w        = waits;
      done     = 1'b0;
      lat      = -1;
      err      = 1'bx;
      rdata    = 'x;
      sel_seen = '0;
      proto_ok = 1'b1;
      for (int k = 0; k < NS; k++) bus.m_prdata_i[k*DW +: DW] = base + 32'(k);
      bus.m_pready_i   = ~onehot;
      bus.m_pslverr_i  = serr ? 4'hF : ~onehot;
      bus.s_psel_i     = 1'b1;
      bus.s_penable_i  = 1'b1;
      bus.s_pwrite_i   = wr;
      bus.s_paddr_i    = addr;
      bus.s_pwdata_i   = wdata;
      for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
         @(posedge ACLK); #1;
         sel_seen |= bus.m_psel_o;
         if (bus.m_psel_o != 4'b0 &&
             (bus.m_paddr_o !== addr || bus.m_pwrite_o !== wr || bus.m_pwdata_o !== wdata))
            proto_ok = 1'b0;
         if (bus.s_pready_o) begin
            if (bus.m_psel_o != 4'b0 || bus.m_penable_o) proto_ok = 1'b0;
            done  = 1'b1;
            lat   = cyc;
            err   = bus.s_pslverr_o;
            rdata = bus.s_prdata_o;
            bus.s_penable_i = 1'b0;
            bus.m_pready_i  = ~onehot;
         end else begin
            if (tgt < 0) begin
               if (bus.m_psel_o != 4'b0 || bus.m_penable_o) proto_ok = 1'b0;
            end else if (bus.m_psel_o !== onehot || bus.m_penable_o !== (cyc != 1)) begin
               proto_ok = 1'b0;
            end
            if (bus.m_penable_o) begin
               if (w > 0) begin
                  bus.m_pready_i = ~onehot;
                  w--;
               end else begin
                  bus.m_pready_i = 4'hF;
               end
            end
         end
      end
      bus.s_penable_i = 1'b0;
      @(posedge ACLK); #1;
      if (bus.s_pready_o || bus.m_psel_o != 4'b0) proto_ok = 1'b0;
   endtask

   task automatic apply(input string tag, input logic [31:0] addr, input logic wr,
                        input logic [31:0] wdata, input int waits, input logic serr,
                        input logic [31:0] base, input int exp_lat, input logic exp_err,
                        input logic [31:0] exp_rdata, input logic [3:0] exp_sel);
      int          lat;
      logic        err;
      logic [31:0] rdata;
      logic [3:0]  sel_seen;
      logic        proto_ok;
      run_xfer(addr, wr, wdata, waits, serr, base, lat, err, rdata, sel_seen, proto_ok);
      check({tag, "_lat"},   64'(lat),      64'(exp_lat));
      check({tag, "_err"},   64'(err),      64'(exp_err));
      check({tag, "_rdata"}, 64'(rdata),    64'(exp_rdata));
      check({tag, "_sel"},   64'(sel_seen), 64'(exp_sel));
      check({tag, "_proto"}, 64'(proto_ok), 64'(1));
   endtask

   initial begin
      start_a[0] = 32'h1A00_0000; end_a[0] = 32'h1A00_FFFF;
      start_a[1] = 32'h1A10_0000; end_a[1] = 32'h1A10_0FFF;
      start_a[2] = 32'h2000_0000; end_a[2] = 32'h2000_FFFF;
      start_a[3] = 32'h2000_8000; end_a[3] = 32'h2001_FFFF;
      for (int k = 0; k < NS; k++) begin
         start_flat[k*AW +: AW] = start_a[k];
         end_flat[k*AW +: AW]   = end_a[k];
      end

      //          addr          wr    wdata         w  serr lat err  rdata         sel
      tbl[0]  = '{32'h1A10_0004, 1'b0, 32'h0,        0, 1'b0, 3, 1'b0, 32'hCAFE_0001, 4'b0010};
      tbl[1]  = '{32'h1A00_0010, 1'b1, 32'h1234_5678, 3, 1'b0, 6, 1'b0, 32'h0,         4'b0001};
      tbl[2]  = '{32'hFFFF_0000, 1'b0, 32'h0,        0, 1'b0, 1, 1'b1, 32'h0,         4'b0000};
      tbl[3]  = '{32'h2000_9000, 1'b0, 32'h0,        0, 1'b0, 3, 1'b0, 32'hCAFE_0002, 4'b0100};
      tbl[4]  = '{32'h2000_9000, 1'b0, 32'h0,        1, 1'b1, 4, 1'b1, 32'hCAFE_0002, 4'b0100};
      tbl[5]  = '{32'h2001_0000, 1'b0, 32'h0,        0, 1'b0, 3, 1'b0, 32'hCAFE_0003, 4'b1000};
      tbl[6]  = '{32'h1A10_0FFF, 1'b0, 32'h0,        2, 1'b0, 5, 1'b0, 32'hCAFE_0001, 4'b0010};
      tbl[7]  = '{32'h1A10_1000, 1'b0, 32'h0,        0, 1'b0, 1, 1'b1, 32'h0,         4'b0000};
      tbl[8]  = '{32'h19FF_FFFF, 1'b0, 32'h0,        0, 1'b0, 1, 1'b1, 32'h0,         4'b0000};
      tbl[9]  = '{32'h1A00_0000, 1'b0, 32'h0,        0, 1'b0, 3, 1'b0, 32'hCAFE_0000, 4'b0001};
      tbl[10] = '{32'h0000_0000, 1'b1, 32'hDEAD_BEEF, 0, 1'b0, 1, 1'b1, 32'h0,         4'b0000};

      ARESETn         = 1'b0;
      bus.s_psel_i    = 1'b0;
      bus.s_penable_i = 1'b0;
      bus.s_pwrite_i  = 1'b0;
      bus.s_paddr_i   = '0;
      bus.s_pwdata_i  = '0;
      bus.m_prdata_i  = '0;
      bus.m_pready_i  = '0;
      bus.m_pslverr_i = '0;
      repeat (3) @(posedge ACLK);
      #1;
      check("rst_pready",  64'(bus.s_pready_o),  64'(0));
      check("rst_pslverr", 64'(bus.s_pslverr_o), 64'(0));
      check("rst_prdata",  64'(bus.s_prdata_o),  64'(0));
      check("rst_psel",    64'(bus.m_psel_o),    64'(0));
      check("rst_penable", 64'(bus.m_penable_o), 64'(0));
      check("rst_maddr",   64'({bus.m_pwrite_o, bus.m_paddr_o, bus.m_pwdata_o}), 64'(0));
      @(negedge ACLK) ARESETn = 1'b1;
      @(posedge ACLK); #1;

      for (int i = 0; i < 11; i++)
         apply($sformatf("vec%0d", i), tbl[i].addr, tbl[i].wr, tbl[i].wdata, tbl[i].waits,
               tbl[i].serr, 32'hCAFE_0000, tbl[i].exp_lat, tbl[i].exp_err,
               tbl[i].exp_rdata, tbl[i].exp_sel);

      // Asynchronous reset while a transfer is stuck in ACCESS.
      bus.m_pready_i  = 4'b1101;
      bus.m_pslverr_i = 4'b0000;
      bus.s_paddr_i   = 32'h1A10_0004;
      bus.s_pwrite_i  = 1'b0;
      bus.s_psel_i    = 1'b1;
      bus.s_penable_i = 1'b1;
      repeat (3) @(posedge ACLK);
      #1;
      check("arst_pre_psel",    64'(bus.m_psel_o),    64'(4'b0010));
      check("arst_pre_penable", 64'(bus.m_penable_o), 64'(1));
      #2 ARESETn = 1'b0;
      #1;
      check("arst_psel",    64'(bus.m_psel_o),    64'(0));
      check("arst_penable", 64'(bus.m_penable_o), 64'(0));
      bus.s_penable_i = 1'b0;
      repeat (2) begin
         @(posedge ACLK); #1;
         check("arst_no_pready", 64'(bus.s_pready_o), 64'(0));
      end
      @(negedge ACLK) ARESETn = 1'b1;
      @(posedge ACLK); #1;
      check("arst_idle_pready", 64'(bus.s_pready_o), 64'(0));
      apply("post_rst", tbl[0].addr, 1'b0, 32'h0, 0, 1'b0, 32'hCAFE_0000,
            3, 1'b0, 32'hCAFE_0001, 4'b0010);

`ifdef APB_NODE_TIMEOUT_EN
      apply("tmo_hung", 32'h1A10_0004, 1'b0, 32'h0, 100, 1'b0, 32'hCAFE_0000,
            2 + TO, 1'b1, 32'h0, 4'b0010);
      apply("tmo_last", 32'h1A10_0004, 1'b0, 32'h0, TO - 1, 1'b0, 32'hCAFE_0000,
            2 + TO, 1'b0, 32'hCAFE_0001, 4'b0010);
`endif

      for (int i = 0; i < 40; i++) begin
         logic [31:0] addr;
         logic [31:0] base;
         logic        wr;
         logic        serr;
         int          waits;
         int          k;
         int          tgt;
         bit          tmo;
         k = int'($urandom_range(0, NS - 1));
         case ($urandom_range(0, 5))
            0:       addr = $urandom;
            1:       addr = start_a[k];
            2:       addr = end_a[k];
            3:       addr = end_a[k] + 32'd1;
            4:       addr = start_a[k] - 32'd1;
            default: addr = start_a[k] + ($urandom % (end_a[k] - start_a[k] + 32'd1));
         endcase
         wr    = 1'($urandom_range(0, 1));
         serr  = 1'($urandom_range(0, 1));
         waits = int'($urandom_range(0, 4));
         base  = $urandom;
         tgt   = ref_idx(addr);
         tmo   = ref_timed_out(tgt, waits);
         apply($sformatf("rnd%0d", i), addr, wr, $urandom, waits, serr, base,
               ref_lat(tgt, waits),
               (tgt < 0 || tmo) ? 1'b1 : serr,
               (tgt < 0 || tmo || wr) ? 32'h0 : base + 32'(tgt),
               (tgt < 0) ? 4'b0000 : 4'(1 << tgt));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
